// File: rtl/mem_arbiter_if.sv
// Bundle between the fetch/load-store requesters, the shared memory port
// and the arbiter that multiplexes them.
interface mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;

    logic        m_en;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    modport slave (
        input  i_req, i_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  m_rdata,
        output i_rdata, i_ack,
        output d_rdata, d_ack,
        output m_en, m_we, m_addr, m_wdata
    );

    modport master (
        output i_req, i_addr,
        output d_req, d_we, d_addr, d_wdata,
        output m_rdata,
        input  i_rdata, i_ack,
        input  d_rdata, d_ack,
        input  m_en, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port I/D memory between fetch and load/store:
// D has fixed priority, a starvation counter forces I after MAXD D grants.
module mem_arbiter #(
    parameter int LAT  = 2,
    parameter int MAXD = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam int CW = $clog2(MAXD + 1);
    localparam int WW = $clog2(LAT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t          state;
    state_t          state_n;

    logic            own_d;
    logic            we_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [WW-1:0]   wcnt;
    logic [CW-1:0]   cnt;
    logic [31:0]     i_rdata_q;
    logic [31:0]     d_rdata_q;

    logic            force_i;
    logic            grant_d;
    logic            grant_i;
    logic            grant;

    // I wins over a pending D only once D has used up its streak.
    assign force_i = bus.i_req && (cnt == CW'(MAXD));
    assign grant_d = bus.d_req && !force_i;
    assign grant_i = bus.i_req && !grant_d;
    assign grant   = grant_d || grant_i;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (grant) state_n = ISSUE;
            ISSUE: state_n = we_q ? RESP : WAIT;
            WAIT:  if (wcnt == '0) state_n = RESP;
            RESP:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            own_d     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wcnt      <= '0;
            cnt       <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            if (state == IDLE && grant) begin
                own_d   <= grant_d;
                we_q    <= grant_d && bus.d_we;
                addr_q  <= grant_d ? bus.d_addr : bus.i_addr;
                wdata_q <= grant_d ? bus.d_wdata : 32'h0;
                if (grant_d && bus.i_req) begin
                    if (cnt != CW'(MAXD)) cnt <= cnt + 1'b1;
                end else begin
                    cnt <= '0;
                end
            end

            if (state == ISSUE) begin
                wcnt <= WW'(LAT - 1);
            end else if (state == WAIT && wcnt != '0) begin
                wcnt <= wcnt - 1'b1;
            end

            // Final WAIT cycle: memory data is valid now.
            if (state == WAIT && wcnt == '0) begin
                if (own_d) d_rdata_q <= bus.m_rdata;
                else       i_rdata_q <= bus.m_rdata;
            end
        end
    end

    always_comb begin
        bus.m_en    = 1'b0;
        bus.m_we    = 1'b0;
        bus.m_addr  = 32'h0;
        bus.m_wdata = 32'h0;
        bus.i_ack   = 1'b0;
        bus.d_ack   = 1'b0;
        unique case (1'b1)
            (state == ISSUE): begin
                bus.m_en    = 1'b1;
                bus.m_we    = we_q;
                bus.m_addr  = addr_q;
                bus.m_wdata = wdata_q;
            end
            (state == RESP): begin
                bus.i_ack = !own_d;
                bus.d_ack = own_d;
            end
            default: ;
        endcase
    end

    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;

endmodule
